// File: rtl/rc4_pkg.sv
// Shared definitions for the RC4 key-search datapath: message length default,
// plaintext character bounds, checker state encoding and the legality test.
package rc4_pkg;

    localparam int MSG_LEN_DEFAULT = 32;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_LO    = 8'h61;
    localparam logic [7:0] CH_HI    = 8'h7A;

    typedef enum logic [1:0] {
        CHK_IDLE = 2'd0,
        CHK_ADDR = 2'd1,
        CHK_DATA = 2'd2,
        CHK_DONE = 2'd3
    } chk_state_t;

    // Legal plaintext is lowercase a..z or a single space; anything else fails.
    function automatic logic is_legal_char(input logic [7:0] b);
        return (b == CH_SPACE) || ((b >= CH_LO) && (b <= CH_HI));
    endfunction

endpackage

// File: rtl/msg_checker.sv
// Scans the decrypted message RAM after an arcfour pass and reports whether
// every byte is legal plaintext, plus the index of the first offending byte.
module msg_checker
    import rc4_pkg::*;
#(
    parameter int MSG_LEN = MSG_LEN_DEFAULT,
    parameter int ADDR_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        aOut,
    output logic [ADDR_W-1:0] aAddr,
    output logic              busy,
    output logic              done,
    output logic              valid,
    output logic [ADDR_W-1:0] bad_index
);

    // Handshake: start is a one-cycle request honoured only in CHK_IDLE; in any
    // other state it is dropped, never queued. done pulses once per accepted start.
    chk_state_t        state;
    logic [ADDR_W-1:0] idx;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(MSG_LEN - 1);
    localparam logic [ADDR_W-1:0] PASS_IDX = ADDR_W'(MSG_LEN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= CHK_IDLE;
            idx       <= '0;
            aAddr     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            valid     <= 1'b0;
            bad_index <= '0;
        end else begin
            case (state)
                CHK_IDLE: begin
                    done  <= 1'b0;
                    aAddr <= '0;
                    if (start) begin
                        state     <= CHK_ADDR;
                        idx       <= '0;
                        busy      <= 1'b1;
                        valid     <= 1'b0;
                        bad_index <= '0;
                    end
                end
                CHK_ADDR: begin
                    // RAM latches aAddr at the end of this cycle; data arrives in DATA.
                    state <= CHK_DATA;
                end
                CHK_DATA: begin
                    if (!is_legal_char(aOut)) begin
                        state     <= CHK_DONE;
                        bad_index <= idx;
                        valid     <= 1'b0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        aAddr     <= '0;
                    end else if (idx == LAST_IDX) begin
                        state     <= CHK_DONE;
                        bad_index <= PASS_IDX;
                        valid     <= 1'b1;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        aAddr     <= '0;
                    end else begin
                        state <= CHK_ADDR;
                        idx   <= idx + ADDR_W'(1);
                        aAddr <= idx + ADDR_W'(1);
                    end
                end
                CHK_DONE: begin
                    state <= CHK_IDLE;
                    done  <= 1'b0;
                    aAddr <= '0;
                end
                default: begin
                    state <= CHK_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    aAddr <= '0;
                end
            endcase
        end
    end

endmodule
